fifo_burst_reader: RTL and testbench

//  Drain side of the byte FIFO: on a start command, pops exactly `count` words from the FIFO

---
 rtl/fifo_burst_reader_pkg.sv | 29 ++
 rtl/fifo_burst_reader_skid.sv | 65 ++++++
 rtl/fifo_burst_reader.sv | 110 +++++++++++
 tb/tb_fifo_burst_reader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// Shared types for the FIFO burst reader.
//   state_e   : burst FSM state, 3-bit encoding
//   SKID_DEPTH: number of words the output buffer can hold
//   credit_ok : pop-credit test used by the top-level pop strobe
package fifo_burst_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_ABORT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int SKID_DEPTH = 2;

  // A new pop lands two edges from now. Its slot is free if the words
  // already committed to the buffer (held + in flight - leaving this cycle)
  // leave room. Counting the outgoing word is what keeps the stream
  // bubble-free at one word per clock, while occ + inflight never exceeds 2.
  function automatic logic credit_ok(input logic [1:0] occ,
                                     input logic       inflight,
                                     input logic       xfer);
    logic [2:0] committed;
    committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};
    return committed < 3'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_burst_reader_skid.sv
// stream_skid2: 2-entry in-order buffer feeding the output stream.
// Ports:
//   clock, reset_n       : clock, synchronous active-low reset
//   push, push_data      : write one word at the tail
//   pop                  : consume the head (ignored when empty)
//   flush                : drop all contents (wins over push/pop)
//   valid, data          : head word; data is a register, stable while held
//   occ                  : occupancy 0..2
module stream_skid2 #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] head, tail;
  logic [1:0]       cnt;
  logic             pop_q;

  assign pop_q = pop && (cnt != 2'd0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop_q})
        2'b10: begin
          if (cnt == 2'd0)      head <= push_data;
          else if (cnt == 2'd1) tail <= push_data;
          if (cnt != 2'd2)      cnt  <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; the new word queues behind whatever remains
          if (cnt == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (cnt != 2'd0);
  assign data  = head;
  assign occ   = cnt;

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops `count` words from a registered-read FIFO and
// presents them on a valid/ready stream, hiding the FIFO read latency.
// Ports:
//   clock, reset_n          : clock, synchronous active-low reset
//   start, count            : burst command (sampled in IDLE only)
//   abort                   : cancel the active burst
//   busy, done, aborted     : status; done is a 1-cycle pulse, aborted valid with it
//   fifo_pop                : FIFO read strobe
//   fifo_data, fifo_nempty  : FIFO read data (cycle after pop), not-empty flag
//   out_valid/out_ready/out_data : output stream
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [COUNT_BITS-1:0] count,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  fifo_pop,
  input  logic [WIDTH-1:0]      fifo_data,
  input  logic                  fifo_nempty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data
);

  state_e                state, state_nxt;
  logic [COUNT_BITS-1:0] remaining, to_send, to_send_nxt;
  logic                  inflight;
  logic                  ab_flag;
  logic [1:0]            occ;
  logic                  in_burst, xfer, push, flush;

  assign in_burst = (state == ST_RUN) || (state == ST_DRAIN);
  assign xfer     = out_valid && out_ready;

  // abort suppresses the pop in the same cycle so no further word leaves the FIFO
  assign fifo_pop = (state == ST_RUN) && (remaining != '0) && fifo_nempty &&
                    !abort && credit_ok(occ, inflight, xfer);

  // a word landing while the burst is being cancelled is discarded
  assign push  = inflight && in_burst && !abort;
  assign flush = in_burst && abort;

  assign to_send_nxt = (xfer && to_send != '0) ? to_send - 1'b1 : to_send;

  stream_skid2 #(.WIDTH(WIDTH)) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (fifo_data),
    .pop       (out_ready),
    .flush     (flush),
    .valid     (out_valid),
    .data      (out_data),
    .occ       (occ)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      to_send   <= '0;
      inflight  <= 1'b0;
      ab_flag   <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_pop;
      if (state == ST_IDLE && start) begin
        remaining <= count;
        to_send   <= count;
        ab_flag   <= 1'b0;
      end else begin
        if (fifo_pop) remaining <= remaining - 1'b1;
        to_send <= to_send_nxt;
      end
      if (flush) ab_flag <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (count == '0) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (abort)                  state_nxt = ST_ABORT;
        else if (remaining == '0)   state_nxt = ST_DRAIN;
      end
      // leave on the cycle of the final transfer so done follows it directly
      ST_DRAIN: begin
        if (abort)                  state_nxt = ST_ABORT;
        else if (to_send_nxt == '0) state_nxt = ST_DONE;
      end
      ST_ABORT: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign aborted = done && ab_flag;

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

  logic        clock = 1'b0;
  logic        reset_n, start, abort, out_ready;
  logic [15:0] count;
  logic        busy, done, aborted, fifo_pop, out_valid;
  logic [7:0]  out_data;
  logic [7:0]  fifo_data = '0;
  logic        fifo_nempty = 1'b0;

  logic        wr_en = 1'b0, fifo_clr = 1'b0;
  logic [7:0]  wr_data = '0;
  logic [7:0]  fq[$];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fifo_burst_reader #(.WIDTH(8), .COUNT_BITS(16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .count       (count),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .fifo_pop    (fifo_pop),
    .fifo_data   (fifo_data),
    .fifo_nempty (fifo_nempty),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
  );

  // FIFO model: registered read data and registered not-empty flag
  always @(posedge clock) begin
    if (fifo_clr) fq.delete();
    else begin
      if (fifo_pop && fq.size() != 0) fifo_data <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
    end
    fifo_nempty <= (fq.size() != 0);
  end

  typedef struct {
    string      name;
    int         pre;       // words preloaded
    logic [7:0] base;      // first preloaded value, increments by 1
    int         cnt;       // burst length
    int         rmode;     // 0: ready held high, 1: ready on even cycles
    int         abort_at;  // -1 none, -2 abort with start, N: abort after N transfers
    int         exp_lat;   // cycle index of first out_valid (-1: never)
    int         exp_done;  // cycle index of done
    int         exp_words;
    int         exp_pops;
    int         exp_ab;
    int         exp_left;  // words left in FIFO
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic preload(input int n, input logic [7:0] base);
    fifo_clr = 1'b1;
    @(posedge clock); #1;
    fifo_clr = 1'b0;
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      @(posedge clock); #1;
    end
    wr_en = 1'b0;
    @(posedge clock); #1;
  endtask

  // Cycle index j = 0 is the cycle after the edge that accepts start.
  task automatic run(input vec_t v);
    int xf, pops, lat, done_at, ahead_max, busy_low, ab_seen_flag;
    bit prev_stall, ab_now, ab_prev, ab_done;
    logic [7:0] prev_d;
    logic ab_flag;
    preload(v.pre, v.base);
    start = 1'b1; count = 16'(v.cnt); abort = (v.abort_at == -2); out_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    xf = 0; pops = 0; lat = -1; done_at = -1; ahead_max = 0; busy_low = 0;
    ab_seen_flag = 0; prev_stall = 0; ab_prev = 0; ab_done = 0; prev_d = '0; ab_flag = 1'b0;
    for (int j = 0; j < 300 && done_at < 0; j++) begin
      ab_now    = (v.abort_at >= 0) && !ab_done && (xf == v.abort_at);
      out_ready = ab_now ? 1'b0 : ((v.rmode == 0) ? 1'b1 : (j % 2 == 0));
      abort     = ab_now;
      #1;
      if (ab_prev) chk({v.name, "_abort_valid_drop"}, out_valid, 0);
      if (ab_now) begin
        ab_done = 1;
        chk({v.name, "_abort_pop_gate"}, fifo_pop, 0);
      end
      if (prev_stall) chk({v.name, "_stall_hold"}, {out_valid, out_data}, {1'b1, prev_d});
      if (out_valid && lat < 0) lat = j;
      if (fifo_pop) pops++;
      if (out_valid && out_ready) begin
        chk({v.name, "_data"}, out_data, 32'(v.base) + 32'(xf));
        xf++;
      end
      if (pops - xf > ahead_max) ahead_max = pops - xf;
      if (done) begin
        done_at = j;
        ab_flag = aborted;
      end else if (!busy) busy_low++;
      prev_stall = out_valid && !out_ready && !ab_now;
      prev_d     = out_data;
      ab_prev    = ab_now;
      @(posedge clock); #1;
    end
    abort = 1'b0;
    chk({v.name, "_done_at"}, done_at, v.exp_done);
    chk({v.name, "_words"}, xf, v.exp_words);
    chk({v.name, "_pops"}, pops, v.exp_pops);
    chk({v.name, "_latency"}, lat, v.exp_lat);
    chk({v.name, "_aborted"}, ab_flag, v.exp_ab);
    chk({v.name, "_ahead_max_le2"}, ahead_max <= 2, 1);
    chk({v.name, "_busy_held"}, busy_low, 0);
    chk({v.name, "_done_pulse"}, {done, busy}, 2'b00);
    chk({v.name, "_fifo_left"}, fq.size(), v.exp_left);
    if (v.abort_at >= 0) ab_seen_flag = ab_done;
    if (v.abort_at >= 0) chk({v.name, "_abort_issued"}, ab_seen_flag, 1);
  endtask

  initial begin
    int xf, done_at, busy_low, done_cnt;

    vecs[0] = '{name:"basic4",  pre:4,  base:8'h11, cnt:4,  rmode:0, abort_at:-1,
                exp_lat:2, exp_done:6,  exp_words:4, exp_pops:4,  exp_ab:0, exp_left:0};
    vecs[1] = '{name:"toggle8", pre:8,  base:8'h20, cnt:8,  rmode:1, abort_at:-1,
                exp_lat:2, exp_done:17, exp_words:8, exp_pops:8,  exp_ab:0, exp_left:0};
    vecs[2] = '{name:"count0",  pre:0,  base:8'h00, cnt:0,  rmode:0, abort_at:-1,
                exp_lat:-1, exp_done:0, exp_words:0, exp_pops:0,  exp_ab:0, exp_left:0};
    vecs[3] = '{name:"abort10", pre:10, base:8'h40, cnt:10, rmode:0, abort_at:4,
                exp_lat:2, exp_done:8,  exp_words:4, exp_pops:6,  exp_ab:1, exp_left:4};
    vecs[4] = '{name:"partial", pre:5,  base:8'h50, cnt:3,  rmode:0, abort_at:-1,
                exp_lat:2, exp_done:5,  exp_words:3, exp_pops:3,  exp_ab:0, exp_left:2};
    vecs[5] = '{name:"st_ab",   pre:2,  base:8'h60, cnt:2,  rmode:0, abort_at:-2,
                exp_lat:2, exp_done:4,  exp_words:2, exp_pops:2,  exp_ab:0, exp_left:0};
    vecs[6] = '{name:"count1",  pre:1,  base:8'h70, cnt:1,  rmode:0, abort_at:-1,
                exp_lat:2, exp_done:3,  exp_words:1, exp_pops:1,  exp_ab:0, exp_left:0};

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; count = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_fifo_pop", fifo_pop, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int k = 0; k < 7; k++) run(vecs[k]);

    // FIFO starts empty; words trickle in 5 cycles apart; a second start mid-burst is ignored
    preload(0, 8'h00);
    start = 1'b1; count = 16'd3; out_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    xf = 0; done_at = -1; busy_low = 0;
    for (int j = 0; j < 60 && done_at < 0; j++) begin
      wr_en   = (j == 2 || j == 7 || j == 12);
      wr_data = 8'hA0 + 8'(j / 5);
      start   = (j == 4);
      count   = 16'd9;
      #1;
      if (out_valid && out_ready) begin
        chk("trickle_data", out_data, 32'hA0 + 32'(xf));
        xf++;
      end
      if (done) done_at = j;
      else if (!busy) busy_low++;
      @(posedge clock); #1;
    end
    wr_en = 1'b0; start = 1'b0;
    chk("trickle_words", xf, 3);
    chk("trickle_done_at", done_at, 16);
    chk("trickle_busy_held", busy_low, 0);

    // reset mid-burst with the buffer full
    preload(6, 8'h80);
    start = 1'b1; count = 16'd6; out_ready = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    chk("midrst_pre_data", {out_valid, out_data}, {1'b1, 8'h80});
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_aborted", aborted, 0);
    chk("midrst_fifo_pop", fifo_pop, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    reset_n = 1'b1;
    done_cnt = 0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clock); #1;
      if (done || busy) done_cnt++;
    end
    chk("midrst_quiet", done_cnt, 0);
    run('{name:"after_rst", pre:2, base:8'h90, cnt:2, rmode:0, abort_at:-1,
          exp_lat:2, exp_done:4, exp_words:2, exp_pops:2, exp_ab:0, exp_left:0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
